// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and alignment check for the load/store unit.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  // size 2'b11 is illegal and is reported the same way as a misalignment
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr[0];
      SZ_WORD: is_misaligned = (addr != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane logic: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ld_data,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged
);

  logic [31:0] shifted;

  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    ld_data = rdata;
    case (size)
      SZ_BYTE: ld_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a combinational-read word RAM; sub-word stores
// are done as read-modify-write, loads return extended lane data.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [ADDR_W+1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misalign,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  state_t              state, state_nxt;
  logic                accept, req_mis;
  logic [1:0]          lane_q, size_q;
  logic                sgn_q, mis_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, merge_q, rdata_q;
  logic [DATA_W-1:0]   ld_data, merged;

  assign accept  = i_valid && (state == IDLE);
  assign req_mis = is_misaligned(i_size, i_addr[1:0]);

  mem_lane_align u_align (
    .rdata    (i_ram_rdata),
    .lane     (lane_q),
    .size     (size_q),
    .sgn      (sgn_q),
    .ld_data  (ld_data),
    .old_word (i_ram_rdata),
    .wdata    (wdata_q),
    .merged   (merged)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_mis)              state_nxt = RESP;
        else if (!i_we)           state_nxt = LOAD;
        else if (i_size == SZ_WORD) state_nxt = WRITE;
        else                      state_nxt = RMW_RD;
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      lane_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lane_q  <= i_addr[1:0];
        size_q  <= i_size;
        sgn_q   <= i_signed;
        mis_q   <= req_mis;
        wdata_q <= i_wdata;
        rdata_q <= '0;
        // RAM-facing registers only move for requests that touch the RAM
        if (!req_mis) addr_q <= i_addr[ADDR_W+1:2];
        if (!req_mis && i_we && i_size == SZ_WORD) merge_q <= i_wdata;
      end
      if (state == LOAD)   rdata_q <= ld_data;
      if (state == RMW_RD) merge_q <= merged;
    end
  end

  assign o_ready     = (state == IDLE);
  assign o_rvalid    = (state == RESP);
  assign o_rdata     = rdata_q;
  assign o_misalign  = mis_q;
  assign o_ram_we    = (state == WRITE);
  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = merge_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a word RAM model and response/write scoreboards.
module tb_mem_lsu;

  localparam int ADDR_W = 5;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic              i_we = 1'b0;
  logic [1:0]        i_size = 2'b00;
  logic              i_signed = 1'b0;
  logic [ADDR_W+1:0] i_addr = '0;
  logic [31:0]       i_wdata = '0;
  logic              o_rvalid;
  logic [31:0]       o_rdata;
  logic              o_misalign;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [31:0]       o_ram_wdata;
  logic [31:0]       i_ram_rdata;

  mem_lsu #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_we(i_we), .i_size(i_size), .i_signed(i_signed), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_misalign(o_misalign), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] mem [32];
  always @(posedge i_clk) if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
  assign i_ram_rdata = mem[o_ram_addr];

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic mis; int cyc; } resp_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  resp_t me;
  wr_t   mw;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion and every RAM write is matched against the queues
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rvalid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: got rvalid, expected none (cycle %0d)", cyc);
        end else begin
          me = rq.pop_front();
          chk("rdata", o_rdata, me.rdata);
          chk("misalign", {31'b0, o_misalign}, {31'b0, me.mis});
          chk("resp_cycle", cyc, me.cyc);
          chk("ready_in_resp", {31'b0, o_ready}, 32'd0);
        end
      end
      if (o_ram_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got write addr %0d data %h, expected none", o_ram_addr, o_ram_wdata);
        end else begin
          mw = wq.pop_front();
          chk("wr_addr", {27'b0, o_ram_addr}, {27'b0, mw.addr});
          chk("wr_data", o_ram_wdata, mw.data);
          chk("wr_cycle", cyc, mw.cyc);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [6:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_mis, input int lat,
                       input int wr_off, input logic [31:0] exp_wdata,
                       input bit track, input bit hold);
    int n = 0;
    int acc;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin @(negedge i_clk); n++; end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got o_ready=0, expected 1 within 50 cycles");
      return;
    end
    i_valid = 1'b1; i_we = we; i_size = size; i_signed = sgn; i_addr = addr; i_wdata = wdata;
    @(posedge i_clk); #1;
    acc = cyc;
    if (track) begin
      rq.push_back('{exp_rdata, exp_mis, acc + lat - 1});
      if (we && !exp_mis) wq.push_back('{addr[6:2], exp_wdata, acc + wr_off});
    end
    chk("ready_busy", {31'b0, o_ready}, 32'd0);
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic ld(input logic [1:0] size, input logic sgn, input logic [6:0] addr,
                    input logic [31:0] exp);
    issue(1'b0, size, sgn, addr, 32'h0, exp, 1'b0, 2, 0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic st(input logic [1:0] size, input logic [6:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_word);
    issue(1'b1, size, 1'b0, addr, wdata, 32'h0, 1'b0, (size == 2'b10) ? 2 : 3,
          (size == 2'b10) ? 0 : 1, exp_word, 1'b1, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin @(negedge i_clk); n++; end
    if (rq.size() != 0 || wq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d responses and %0d writes pending, expected 0", rq.size(), wq.size());
      rq.delete(); wq.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},    {31'b0, o_ready},    32'd1);
    chk({tag, "_rvalid"},   {31'b0, o_rvalid},   32'd0);
    chk({tag, "_rdata"},    o_rdata,             32'd0);
    chk({tag, "_misalign"}, {31'b0, o_misalign}, 32'd0);
    chk({tag, "_ram_we"},   {31'b0, o_ram_we},   32'd0);
    chk({tag, "_ram_addr"}, {27'b0, o_ram_addr}, 32'd0);
    chk({tag, "_ram_wdata"}, o_ram_wdata,        32'd0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk_reset_outputs("rst");
    i_rst_n = 1'b1;

    // word store then load
    st(2'b10, 7'h0C, 32'hDEADBEEF, 32'hDEADBEEF);
    ld(2'b10, 1'b0, 7'h0C, 32'hDEADBEEF);

    // byte RMW with junk in the upper wdata bits, then byte loads
    st(2'b10, 7'h0C, 32'hABBADEAD, 32'hABBADEAD);
    st(2'b00, 7'h0E, 32'hFFFFFF55, 32'hAB55DEAD);
    ld(2'b00, 1'b1, 7'h0F, 32'hFFFFFFAB);
    ld(2'b00, 1'b0, 7'h0F, 32'h000000AB);
    ld(2'b00, 1'b1, 7'h0E, 32'h00000055);
    ld(2'b00, 1'b1, 7'h0C, 32'hFFFFFFAD);

    // halfwords in the top word
    st(2'b10, 7'h7C, 32'h00000000, 32'h00000000);
    st(2'b01, 7'h7C, 32'h7777BEEF, 32'h0000BEEF);
    st(2'b01, 7'h7E, 32'h00001234, 32'h1234BEEF);
    ld(2'b01, 1'b1, 7'h7C, 32'hFFFFBEEF);
    ld(2'b01, 1'b0, 7'h7E, 32'h00001234);
    ld(2'b10, 1'b0, 7'h7C, 32'h1234BEEF);
    drain();
    chk("ram31", mem[31], 32'h1234BEEF);

    // misaligned / illegal requests: 1-cycle error, no RAM access
    st(2'b10, 7'h00, 32'h01020304, 32'h01020304);
    st(2'b10, 7'h04, 32'h05060708, 32'h05060708);
    issue(1'b0, 2'b01, 1'b1, 7'h05, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 7'h02, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 7'h00, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 2'b11, 1'b0, 7'h04, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1, 1'b0);
    drain();
    chk("mis_ram0", mem[0], 32'h01020304);
    chk("mis_ram1", mem[1], 32'h05060708);

    // back-to-back with i_valid held high
    issue(1'b0, 2'b10, 1'b0, 7'h0C, 32'h0,        32'hAB55DEAD, 1'b0, 2, 0, 32'h0,        1'b1, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 7'h0D, 32'h0,        32'h000000DE, 1'b0, 2, 0, 32'h0,        1'b1, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 7'h08, 32'hCAFEF00D, 32'h0,        1'b0, 2, 0, 32'hCAFEF00D, 1'b1, 1'b0);
    ld(2'b10, 1'b0, 7'h08, 32'hCAFEF00D);
    drain();

    // reset while a byte store sits in RMW_RD
    st(2'b10, 7'h0C, 32'h11111111, 32'h11111111);
    drain();
    issue(1'b1, 2'b00, 1'b0, 7'h0C, 32'h00000055, 32'h0, 1'b0, 3, 1, 32'h0, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk("rst_ram_we_async", {31'b0, o_ram_we}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk_reset_outputs("post_rst");
    repeat (3) @(negedge i_clk);
    chk("post_rst_ram3", mem[3], 32'h11111111);
    chk("post_rst_rvalid", {31'b0, o_rvalid}, 32'd0);
    ld(2'b10, 1'b0, 7'h0C, 32'h11111111);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected end within 200000 time units");
    $fatal(1);
  end

endmodule
